tdm_demux14: RTL and testbench

//   Receive end of the 4:1 channel mux. Accepts one time-division-multiplexed

---
 rtl/tdm_demux14.sv | 141 ++++++++++++++
 tb/tb_tdm_demux14.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/tdm_demux14.sv
// Receive side of the 4:1 TDM channel mux: rebuilds channels D0..D3 from a
// slotted stream and releases them only as complete, frame-atomic updates.
module tdm_demux14 #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic             frame_sync,
  output logic [WIDTH-1:0] D0,
  output logic [WIDTH-1:0] D1,
  output logic [WIDTH-1:0] D2,
  output logic [WIDTH-1:0] D3,
  output logic [1:0]       S,
  output logic             frame_valid,
  output logic             sync_err,
  output logic             locked,
  output logic [CNT_W-1:0] frame_cnt
);

  typedef enum logic {
    HUNT = 1'b0,
    LOCK = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       s_q, s_d;
  logic [WIDTH-1:0] sh0_q, sh0_d, sh1_q, sh1_d, sh2_q, sh2_d;
  logic [WIDTH-1:0] d0_q, d0_d, d1_q, d1_d, d2_q, d2_d, d3_q, d3_d;
  logic             frame_valid_q, frame_valid_d;
  logic             sync_err_q, sync_err_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;

  // Next-state: slots 0..2 go to shadow regs, slot 3 commits the whole frame.
  always_comb begin
    state_d       = state_q;
    s_d           = s_q;
    sh0_d         = sh0_q;
    sh1_d         = sh1_q;
    sh2_d         = sh2_q;
    d0_d          = d0_q;
    d1_d          = d1_q;
    d2_d          = d2_q;
    d3_d          = d3_q;
    frame_valid_d = 1'b0;
    sync_err_d    = 1'b0;
    frame_cnt_d   = frame_cnt_q;

    if (din_valid) begin
      case (state_q)
        HUNT: begin
          if (frame_sync) begin
            sh0_d   = din;
            s_d     = 2'd1;
            state_d = LOCK;
          end
        end
        LOCK: begin
          if (frame_sync) begin
            // An early sync abandons the partial frame and restarts at slot 0.
            sync_err_d = (s_q != 2'd0);
            sh0_d      = din;
            s_d        = 2'd1;
          end else begin
            case (s_q)
              2'd0: begin
                sync_err_d = 1'b1;
                state_d    = HUNT;
                s_d        = 2'd0;
              end
              2'd1: begin
                sh1_d = din;
                s_d   = 2'd2;
              end
              2'd2: begin
                sh2_d = din;
                s_d   = 2'd3;
              end
              default: begin
                d0_d          = sh0_q;
                d1_d          = sh1_q;
                d2_d          = sh2_q;
                d3_d          = din;
                frame_valid_d = 1'b1;
                frame_cnt_d   = frame_cnt_q + CNT_W'(1);
                s_d           = 2'd0;
              end
            endcase
          end
        end
        default: begin
          state_d = HUNT;
          s_d     = 2'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= HUNT;
      s_q           <= 2'd0;
      sh0_q         <= '0;
      sh1_q         <= '0;
      sh2_q         <= '0;
      d0_q          <= '0;
      d1_q          <= '0;
      d2_q          <= '0;
      d3_q          <= '0;
      frame_valid_q <= 1'b0;
      sync_err_q    <= 1'b0;
      frame_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      s_q           <= s_d;
      sh0_q         <= sh0_d;
      sh1_q         <= sh1_d;
      sh2_q         <= sh2_d;
      d0_q          <= d0_d;
      d1_q          <= d1_d;
      d2_q          <= d2_d;
      d3_q          <= d3_d;
      frame_valid_q <= frame_valid_d;
      sync_err_q    <= sync_err_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

  assign D0          = d0_q;
  assign D1          = d1_q;
  assign D2          = d2_q;
  assign D3          = d3_q;
  assign S           = s_q;
  assign frame_valid = frame_valid_q;
  assign sync_err    = sync_err_q;
  assign locked      = (state_q == LOCK);
  assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_tdm_demux14.sv
// Scoreboard bench for tdm_demux14: expected frame/error events are queued by
// the stimulus and popped by an independent monitor on each output pulse.
module tb_tdm_demux14;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             frame_sync;
  logic [WIDTH-1:0] D0, D1, D2, D3;
  logic [1:0]       S;
  logic             frame_valid;
  logic             sync_err;
  logic             locked;
  logic [CNT_W-1:0] frame_cnt;

  typedef struct packed {
    logic             is_err;
    logic [WIDTH-1:0] d0;
    logic [WIDTH-1:0] d1;
    logic [WIDTH-1:0] d2;
    logic [WIDTH-1:0] d3;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  tdm_demux14 #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
    .frame_sync(frame_sync), .D0(D0), .D1(D1), .D2(D2), .D3(D3), .S(S),
    .frame_valid(frame_valid), .sync_err(sync_err), .locked(locked),
    .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic push_frame(input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] c, input logic [7:0] d,
                            input logic [CNT_W-1:0] cnt);
    exp_t e;
    e = '{is_err: 1'b0, d0: a, d1: b, d2: c, d3: d, cnt: cnt};
    exp_q.push_back(e);
  endtask

  task automatic push_err();
    exp_t e;
    e = '0;
    e.is_err = 1'b1;
    exp_q.push_back(e);
  endtask

  task automatic beat(input logic [7:0] d, input logic sync);
    @(negedge clk);
    din        = d;
    din_valid  = 1'b1;
    frame_sync = sync;
  endtask

  task automatic idle();
    @(negedge clk);
    din        = 8'($urandom);
    din_valid  = 1'b0;
    frame_sync = 1'($urandom);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_D"}, {D0, D1, D2, D3}, 32'h0);
    check({tag, "_S"}, 32'(S), 32'h0);
    check({tag, "_pulses"}, {30'h0, frame_valid, sync_err}, 32'h0);
    check({tag, "_locked"}, 32'(locked), 32'h0);
    check({tag, "_cnt"}, 32'(frame_cnt), 32'h0);
  endtask

  // Monitor: every output pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (frame_valid === 1'b1 || sync_err === 1'b1) begin
      exp_t e;
      check("pulse_exclusive", 32'(frame_valid & sync_err), 32'h0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse actual fv=%0b err=%0b required=none",
                 frame_valid, sync_err);
      end else begin
        e = exp_q.pop_front();
        check("pulse_kind", 32'(sync_err), 32'(e.is_err));
        if (!e.is_err) begin
          check("frame_data", {D0, D1, D2, D3}, {e.d0, e.d1, e.d2, e.d3});
          check("frame_cnt", 32'(frame_cnt), 32'(e.cnt));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    // 1: reset with random input activity
    rst_n = 1'b0;
    din = '0; din_valid = 1'b0; frame_sync = 1'b0;
    repeat (2) begin
      @(negedge clk);
      din = 8'($urandom); din_valid = 1'($urandom); frame_sync = 1'($urandom);
    end
    @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1; din_valid = 1'b0;

    // 2: single back-to-back frame
    push_frame(8'hA1, 8'hB2, 8'hC3, 8'hD4, 2'd1);
    beat(8'hA1, 1'b1);
    check("hunt_S", 32'(S), 32'h0);
    beat(8'hB2, 1'b0);
    check("first_lock", 32'(locked), 32'h1);
    beat(8'hC3, 1'b0);
    beat(8'hD4, 1'b0);
    idle();
    check("single_S", 32'(S), 32'h0);
    check("single_locked", 32'(locked), 32'h1);

    // 3: gapped frame then back-to-back frame
    push_frame(8'h11, 8'h22, 8'h33, 8'h44, 2'd2);
    push_frame(8'h55, 8'h66, 8'h77, 8'h88, 2'd3);
    beat(8'h11, 1'b1); idle();
    beat(8'h22, 1'b0); idle();
    check("gap_S", 32'(S), 32'h2);
    idle();
    check("gap_D_held", {D0, D1, D2, D3}, 32'hA1B2C3D4);
    beat(8'h33, 1'b0); idle();
    beat(8'h44, 1'b0);
    beat(8'h55, 1'b1);
    beat(8'h66, 1'b0);
    beat(8'h77, 1'b0);
    beat(8'h88, 1'b0);
    idle();
    check("b2b_D", {D0, D1, D2, D3}, 32'h55667788);

    // 4: early sync discards the partial frame
    push_err();
    push_frame(8'hEE, 8'hF1, 8'hF2, 8'hF3, 2'd0);
    beat(8'h01, 1'b1);
    beat(8'h02, 1'b0);
    beat(8'hEE, 1'b1);
    beat(8'hF1, 1'b0);
    check("early_locked", 32'(locked), 32'h1);
    check("early_D_held", {D0, D1, D2, D3}, 32'h55667788);
    beat(8'hF2, 1'b0);
    beat(8'hF3, 1'b0);
    idle();

    // 5: missing sync at slot 0 drops lock until the next sync beat
    push_err();
    beat(8'h99, 1'b0);
    idle();
    check("lost_locked", 32'(locked), 32'h0);
    check("lost_S", 32'(S), 32'h0);
    beat(8'h10, 1'b0);
    beat(8'h20, 1'b0);
    idle();
    check("hunt_drop_locked", 32'(locked), 32'h0);
    check("hunt_drop_D", {D0, D1, D2, D3}, 32'hEEF1F2F3);
    push_frame(8'h30, 8'h31, 8'h32, 8'h33, 2'd1);
    beat(8'h30, 1'b1);
    beat(8'h31, 1'b0);
    beat(8'h32, 1'b0);
    beat(8'h33, 1'b0);
    idle();
    check("relock", 32'(locked), 32'h1);

    // 6: counter wrap over five frames, then reset mid-frame
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    for (int f = 0; f < 5; f++) begin
      logic [7:0] base;
      base = 8'(8'h40 + 8'(f * 16));
      push_frame(base, base + 8'd1, base + 8'd2, base + 8'd3, CNT_W'(f + 1));
      beat(base, 1'b1);
      beat(base + 8'd1, 1'b0);
      beat(base + 8'd2, 1'b0);
      beat(base + 8'd3, 1'b0);
    end
    idle();
    check("wrap_cnt", 32'(frame_cnt), 32'h1);
    check("wrap_D", {D0, D1, D2, D3}, 32'h80818283);
    beat(8'hC0, 1'b1);
    beat(8'hC1, 1'b0);
    @(negedge clk);
    rst_n = 1'b0; din = 8'hC2; din_valid = 1'b1; frame_sync = 1'b0;
    @(negedge clk);
    check_all_zero("midreset");
    rst_n = 1'b1;
    din = 8'hC3; din_valid = 1'b1; frame_sync = 1'b0;
    beat(8'hC4, 1'b0);
    idle();
    idle();
    check("post_reset_locked", 32'(locked), 32'h0);
    check("post_reset_D", {D0, D1, D2, D3}, 32'h0);

    check("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
